// File: rtl/apb_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_requester                                                |
// | Description : APB bus master. Accepts single commands on a valid/ready     |
// |               port, runs them as SETUP -> ACCESS transfers, and returns a  |
// |               one-cycle response (read data, slave error, timeout,         |
// |               misalignment). Back-to-back transfers skip the IDLE phase.   |
// | Ports       : pclk/presetn      clock, synchronous active-low reset        |
// |               cmd_*             command request (valid/ready)              |
// |               rsp_*             one-cycle response pulse and status        |
// |               psel..pprot       APB request outputs                        |
// |               prdata/pready/pslverr  APB completion inputs                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module apb_requester #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ALIGNBITS  = $clog2(STRB_WIDTH);
  localparam int CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_waitCnt;
  // A misaligned command accepted on the completion cycle of a transfer would
  // collide with that transfer's response, so its error response is deferred
  // by one cycle through this flag.
  logic             r_misPend;

  logic w_accept;
  logic w_misaligned;
  logic w_startXfer;

  generate
    if (ALIGNBITS > 0) begin : g_align
      assign w_misaligned = |cmd_addr[ALIGNBITS-1:0];
    end else begin : g_noAlign
      assign w_misaligned = 1'b0;
    end
  endgenerate

  assign cmd_ready   = (r_state == S_IDLE) || ((r_state == S_ACCESS) && pready);
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_startXfer = w_accept && !w_misaligned;

  // Bus phase is a pure decode of the state, so reset drops psel/penable at
  // the same edge that returns the FSM to IDLE.
  assign psel    = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign penable = (r_state == S_ACCESS);

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state     <= S_IDLE;
      r_waitCnt   <= '0;
      r_misPend   <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;

      // APB request fields only change when a new transfer enters SETUP.
      if (w_startXfer) begin
        pwrite    <= cmd_write;
        paddr     <= cmd_addr;
        pwdata    <= cmd_write ? cmd_wdata : '0;
        pstrb     <= cmd_write ? cmd_strb : '0;
        pprot     <= cmd_prot;
        r_waitCnt <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (r_misPend) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            r_misPend <= 1'b0;
          end
          if (w_accept) begin
            if (w_misaligned) begin
              // Response slot already taken by the deferred one: defer again.
              if (r_misPend) begin
                r_misPend <= 1'b1;
              end else begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
              end
            end else begin
              r_state <= S_SETUP;
            end
          end
        end

        S_SETUP: begin
          r_state <= S_ACCESS;
        end

        S_ACCESS: begin
          if (pready) begin
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
            if (w_accept && !w_misaligned) begin
              r_state <= S_SETUP;
            end else begin
              r_state <= S_IDLE;
              if (w_accept) begin
                r_misPend <= 1'b1;
              end
            end
          end else if (r_waitCnt == C_CNT_LAST) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_apb_requester                                             |
// | Description : Self-checking bench for apb_requester with a small APB       |
// |               peripheral model and a response scoreboard.                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_apb_requester;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          pclk;
  logic          presetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------- peripheral model ----------------
  logic [31:0] mem [0:15] = '{default: 32'h0};
  int accCnt     = 0;
  int waitStates = 0;
  bit slvStuck   = 1'b0;
  bit slvErr     = 1'b0;

  assign pready  = psel && penable && !slvStuck && (accCnt >= waitStates);
  assign pslverr = slvErr && pready;
  assign prdata  = (psel && !pwrite) ? mem[paddr[5:2]] : 32'h0;

  always @(posedge pclk) begin
    if (psel && penable && !pready) accCnt <= accCnt + 1;
    else                            accCnt <= 0;
    if (pready && pwrite && !slvErr)
      for (int b = 0; b < 4; b++)
        if (pstrb[b]) mem[paddr[5:2]][8*b +: 8] <= pwdata[8*b +: 8];
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  rsp_t expQ[$];
  rsp_t expItem;
  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge pclk) begin
    if (rsp_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        nChecks++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%0h err=%0b tmo=%0b, expected no response",
                 rsp_rdata, rsp_err, rsp_timeout);
      end else begin
        expItem = expQ.pop_front();
        chk("rsp_rdata",   64'(rsp_rdata),   64'(expItem.rdata));
        chk("rsp_err",     64'(rsp_err),     64'(expItem.err));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(expItem.tmo));
      end
    end
  end

  // Drives a command (called just after a rising edge), waits for acceptance and
  // returns 1 ns after the accepting edge with cmd_valid still asserted.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot, input bit push,
                       input logic [31:0] erd, input bit eerr, input bit etmo);
    int n;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = prot;
    n = 0;
    @(negedge pclk);
    while (!cmd_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    if (!cmd_ready) chk("accept_bound", 64'(cmd_ready), 64'(1));
    if (push) expQ.push_back(rsp_t'({erd, eerr, etmo}));
    @(posedge pclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    bit stable;
    logic [4:0] pselPat, penPat;

    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("reset_psel_pen",  64'({psel, penable}), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_apb_regs",  64'({pwrite, paddr, pstrb, pprot}), 64'(0));
    @(posedge pclk); #1 presetn = 1'b1;

    // 1: zero-wait write
    waitStates = 0;
    issue(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 3'h5, 1'b1, 32'h0, 1'b0, 1'b0);
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk("t1_setup_psel_pen", 64'({psel, penable}), 64'(2'b10));
    chk("t1_setup_ctrl",     64'({pwrite, pstrb, pprot}), 64'({1'b1, 4'hF, 3'h5}));
    chk("t1_setup_paddr",    64'(paddr), 64'(32'h8));
    chk("t1_setup_pwdata",   64'(pwdata), 64'(32'hDEADBEEF));
    @(negedge pclk);
    chk("t1_access_psel_pen", 64'({psel, penable}), 64'(2'b11));
    @(negedge pclk);
    chk("t1_rsp_latency", 64'(rsp_valid), 64'(1));
    chk("t1_idle_psel",   64'(psel), 64'(0));
    @(posedge pclk); #1;

    // 2: read with 3 wait states
    waitStates = 3;
    issue(1'b0, 32'h8, 32'h11111111, 4'hF, 3'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk("t2_setup_rd_ctrl", 64'({pwrite, pstrb, pwdata}), 64'(0));
    n = 0; stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (!(psel && penable)) break;
      n++;
      if (paddr !== 32'h8 || pstrb !== 4'h0) stable = 1'b0;
    end
    chk("t2_access_cycles", 64'(n), 64'(4));
    chk("t2_access_stable", 64'(stable), 64'(1));
    chk("t2_rsp_latency",   64'(rsp_valid), 64'(1));
    @(posedge pclk); #1;

    // 3: back-to-back write then read, cmd_valid held
    waitStates = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4;
    cmd_wdata = 32'h12345678; cmd_strb = 4'h3; cmd_prot = 3'h0;
    expQ.push_back(rsp_t'({32'h0, 1'b0, 1'b0}));
    @(negedge pclk);
    chk("t3_ready_idle", 64'(cmd_ready), 64'(1));
    @(posedge pclk); #1;
    cmd_write = 1'b0;
    expQ.push_back(rsp_t'({32'h00005678, 1'b0, 1'b0}));
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      pselPat[i] = psel;
      penPat[i]  = penable;
      if (i == 1) chk("t3_ready_on_complete", 64'(cmd_ready), 64'(1));
      @(posedge pclk); #1;
      if (i == 1) cmd_valid = 1'b0;
    end
    chk("t3_psel_pattern",    64'(pselPat), 64'(5'h0F));
    chk("t3_penable_pattern", 64'(penPat),  64'(5'h0A));

    // 4: misaligned read
    issue(1'b0, 32'h6, 32'h0, 4'h0, 3'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk("t4_no_psel",     64'(psel), 64'(0));
    chk("t4_rsp_latency", 64'(rsp_valid), 64'(1));
    @(posedge pclk); #1;

    // 5: pready stuck low -> timeout
    slvStuck = 1'b1;
    issue(1'b0, 32'h0, 32'h0, 4'h0, 3'h0, 1'b1, 32'h0, 1'b1, 1'b1);
    cmd_valid = 1'b0;
    @(negedge pclk);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      if (!(psel && penable)) break;
      n++;
    end
    chk("t5_access_cycles", 64'(n), 64'(TO));
    chk("t5_psel_dropped",  64'(psel), 64'(0));
    chk("t5_rsp_latency",   64'(rsp_valid), 64'(1));
    slvStuck = 1'b0;
    @(posedge pclk); #1;

    // 6a: slave error on a write
    slvErr = 1'b1;
    issue(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 3'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    repeat (3) @(negedge pclk);
    chk("t6_err_rsp_latency", 64'(rsp_valid), 64'(1));
    slvErr = 1'b0;
    @(posedge pclk); #1;

    // 6b: reset asserted during ACCESS
    slvStuck = 1'b1;
    issue(1'b1, 32'hC, 32'hA5A5A5A5, 4'hF, 3'h7, 1'b0, 32'h0, 1'b0, 1'b0);
    cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    chk("t6_in_access", 64'({psel, penable}), 64'(2'b11));
    @(posedge pclk); #1 presetn = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    chk("t6_rst_psel_pen", 64'({psel, penable}), 64'(0));
    chk("t6_rst_paddr",    64'(paddr), 64'(0));
    chk("t6_rst_pwdata",   64'(pwdata), 64'(0));
    chk("t6_rst_ctrl",     64'({pwrite, pstrb, pprot}), 64'(0));
    chk("t6_rst_rsp",      64'(rsp_valid), 64'(0));
    chk("t6_rst_ready",    64'(cmd_ready), 64'(1));
    slvStuck = 1'b0;
    @(posedge pclk); #1 presetn = 1'b1;
    repeat (6) @(negedge pclk);

    chk("scoreboard_drained", 64'(expQ.size()), 64'(0));
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
